sm_uart_msg_rx: RTL

//  Parametrised successor of the Xbee SPM receiver: UART byte receiver plus supply-position message decoder.
//  - Deserialises 8N1 serial data from the Xbee.
//  - Maps colour characters into a NUM_SLOTS-deep slot buffer.
//  - Once the message is complete, streams (index, colour) pairs to the bot controller over a valid/ready handshake.
//  - Adds input synchronisation, start-bit glitch rejection, framing-error detection, back-pressure and re-arm via clear.

---
 rtl/sm_uart_msg_rx.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sm_uart_msg_rx.sv
// sm_uart_msg_rx: UART (8N1) byte receiver plus supply-position message decoder.
// Serial bytes from the Xbee are deserialised. Colour characters are stored in a
// slot buffer. Once the message completes, the (index, colour) pairs are streamed
// out over a valid/ready handshake.
//
// Ports:
//   clk_50m   in   system clock
//   rst_n     in   asynchronous active-low reset
//   rx        in   UART serial input; idle high; asynchronous to clk_50m
//   clear     in   1-cycle pulse; aborts or finishes the message and re-arms
//   out_valid out  out_index/out_color hold a valid slot
//   out_ready in   consumer accepts the slot when out_valid & out_ready
//   out_index out  slot number, 0-based
//   out_color out  slot colour: 0=N 1=R 2=B 3=G
//   msg_done  out  every stored slot has been streamed; held until clear
//   frame_err out  1-cycle pulse on a bad stop bit (or bad parity)
//   busy      out  UART FSM not idle
//
// Build option: define SM_RX_PARITY_EN to add an even-parity bit between the
// data and stop bits. Without it the format is plain 8N1.
//
// UART FSM
//   state  | meaning
//   IDLE   | waiting for a falling edge on rxs
//   START  | timing to mid start bit, rejects glitches
//   DATA   | sampling 8 data bits, LSB first
//   PARITY | (SM_RX_PARITY_EN only) checking even parity
//   STOP   | sampling the stop bit
// Decoder FSM
//   state   | meaning
//   COLLECT | storing colour codes until '#' or the buffer is full
//   DRAIN   | streaming stored slots to the consumer
//   DONE    | message fully streamed, waiting for clear
module sm_uart_msg_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_SLOTS    = 8,
  parameter int IDX_W        = 4
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             rx,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [1:0]       out_color,
  output logic             msg_done,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W:0]   LAST_WR = (IDX_W + 1)'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    U_IDLE,
    U_START,
    U_DATA,
`ifdef SM_RX_PARITY_EN
    U_PARITY,
`endif
    U_STOP
  } uart_state_t;

  typedef enum logic [1:0] {D_COLLECT, D_DRAIN, D_DONE} dec_state_t;

  logic rx_meta, rxs;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  uart_state_t      u_state, u_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             byte_stb, byte_stb_nxt, frame_err_nxt;

  always_comb begin
    u_nxt         = u_state;
    cnt_nxt       = cnt + CNT_W'(1);
    bit_idx_nxt   = bit_idx;
    shreg_nxt     = shreg;
    byte_stb_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    unique case (u_state)
      U_IDLE: begin
        cnt_nxt = '0;
        if (!rxs) u_nxt = U_START;
      end
      U_START: begin
        if (cnt == HALF_TC) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          u_nxt       = rxs ? U_IDLE : U_DATA;
        end
      end
      U_DATA: begin
        if (cnt == FULL_TC) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rxs, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
`ifdef SM_RX_PARITY_EN
          if (bit_idx == 3'd7) u_nxt = U_PARITY;
`else
          if (bit_idx == 3'd7) u_nxt = U_STOP;
`endif
        end
      end
`ifdef SM_RX_PARITY_EN
      U_PARITY: begin
        if (cnt == FULL_TC) begin
          cnt_nxt = '0;
          // Even parity: data plus parity bit must hold an even number of ones.
          if (^{shreg, rxs}) begin
            frame_err_nxt = 1'b1;
            u_nxt         = U_IDLE;
          end else begin
            u_nxt = U_STOP;
          end
        end
      end
`endif
      U_STOP: begin
        if (cnt == FULL_TC) begin
          cnt_nxt = '0;
          u_nxt   = U_IDLE;
          if (rxs) byte_stb_nxt  = 1'b1;
          else     frame_err_nxt = 1'b1;
        end
      end
      default: u_nxt = U_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      u_state   <= U_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      u_state   <= u_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      byte_stb  <= byte_stb_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  assign busy = (u_state != U_IDLE);

  // shreg stays stable from the last data bit until the next frame, so it is
  // still the received byte on the byte_stb cycle.
  dec_state_t       d_state, d_nxt;
  logic [IDX_W:0]   wr_ptr;
  logic [IDX_W-1:0] rd_ptr;
  logic [1:0]       slot [2**IDX_W];
  logic             is_colour, accept, last_rd;
  logic [1:0]       code;

  always_comb begin
    is_colour = 1'b1;
    code      = 2'd0;
    case (shreg)
      8'h52:   code = 2'd1;
      8'h42:   code = 2'd2;
      8'h47:   code = 2'd3;
      8'h4E:   code = 2'd0;
      default: is_colour = 1'b0;
    endcase
  end

  assign accept  = out_valid & out_ready;
  assign last_rd = (({1'b0, rd_ptr} + (IDX_W + 1)'(1)) == wr_ptr);

  always_comb begin
    d_nxt = d_state;
    unique case (d_state)
      D_COLLECT: begin
        if (byte_stb) begin
          if (is_colour && wr_ptr == LAST_WR) d_nxt = D_DRAIN;
          else if (shreg == 8'h23)            d_nxt = (wr_ptr == '0) ? D_DONE : D_DRAIN;
        end
      end
      D_DRAIN: if (accept && last_rd) d_nxt = D_DONE;
      D_DONE:  d_nxt = D_DONE;
      default: d_nxt = D_COLLECT;
    endcase
    if (clear) d_nxt = D_COLLECT;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) d_state <= D_COLLECT;
    else        d_state <= d_nxt;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_color <= 2'd0;
      msg_done  <= 1'b0;
      for (int i = 0; i < 2**IDX_W; i++) slot[i] <= 2'd0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_color <= 2'd0;
      msg_done  <= 1'b0;
      for (int i = 0; i < 2**IDX_W; i++) slot[i] <= 2'd0;
    end else begin
      case (d_state)
        D_COLLECT: begin
          if (byte_stb && is_colour) begin
            slot[wr_ptr[IDX_W-1:0]] <= code;
            wr_ptr <= wr_ptr + (IDX_W + 1)'(1);
          end
        end
        D_DRAIN: begin
          if (accept && !last_rd) begin
            rd_ptr    <= rd_ptr + IDX_W'(1);
            out_color <= slot[rd_ptr + IDX_W'(1)];
          end
        end
        default: ;
      endcase
      // Completing on a full buffer writes the last slot, never slot 0
      // (NUM_SLOTS >= 2), so slot[0] is already final here.
      if (d_state != D_DRAIN && d_nxt == D_DRAIN) begin
        out_valid <= 1'b1;
        rd_ptr    <= '0;
        out_color <= slot[0];
      end else if (d_state == D_DRAIN && d_nxt == D_DONE) begin
        out_valid <= 1'b0;
      end
      if (d_state != D_DONE && d_nxt == D_DONE) msg_done <= 1'b1;
    end
  end

  assign out_index = rd_ptr;

endmodule
